// File: rtl/photonic_switch_pkg.sv
// Shared widths and FSM encoding for the photonic switch pulse driver.
package photonic_switch_pkg;

    localparam int unsigned CW_DEF = 7;
    localparam int unsigned FW_DEF = 8;

    localparam logic [1:0] ENC_IDLE    = 2'd0;
    localparam logic [1:0] ENC_DELAY   = 2'd1;
    localparam logic [1:0] ENC_ACTIVE  = 2'd2;
    localparam logic [1:0] ENC_HOLDOFF = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ENC_IDLE,
        DELAY   = ENC_DELAY,
        ACTIVE  = ENC_ACTIVE,
        HOLDOFF = ENC_HOLDOFF
    } state_t;

endpackage

// File: rtl/sw_timer.sv
// Loadable down-counter shared by the DELAY, ACTIVE and HOLDOFF phases.
module sw_timer
    import photonic_switch_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
) (
    input  logic          counter_clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          zero
);

    logic [CW-1:0] tmr;

    // Load has priority; otherwise count down and rest at zero.
    always_ff @(posedge counter_clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr <= '0;
        end else if (load) begin
            tmr <= value;
        end else if (tmr != '0) begin
            tmr <= tmr - CW'(1);
        end
    end

    assign zero = (tmr == '0);

endmodule

// File: rtl/photonic_switch_driver.sv
// Turns each new comparator match into one timed photonic switch drive pulse
// with programmable start delay, width and post-pulse holdoff.
module photonic_switch_driver
    import photonic_switch_pkg::*;
#(
    parameter int unsigned CW = CW_DEF,
    parameter int unsigned FW = FW_DEF
) (
    input  logic          counter_clk,
    input  logic          reset_n,
    input  logic          comp_in,
    input  logic          arm,
    input  logic          abort,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] width,
    input  logic [CW-1:0] holdoff,
    input  logic          clr_missed,
    output logic          sw_out,
    output logic          busy,
    output logic [FW-1:0] fire_cnt,
    output logic          missed
);

    state_t        state, state_nxt;
    logic          comp_q;
    logic          trig;
    logic          accept;
    logic [CW-1:0] cfg_width;
    logic [CW-1:0] cfg_holdoff;
    logic          tmr_load;
    logic [CW-1:0] tmr_value;
    logic          tmr_zero;
    logic          sw_out_nxt;
    logic          busy_nxt;
    logic [FW-1:0] fire_nxt;
    logic          missed_nxt;

    assign trig   = comp_in & ~comp_q;
    assign accept = trig & arm & ~abort & (state == IDLE);

    sw_timer #(.CW(CW)) u_timer (
        .counter_clk (counter_clk),
        .reset_n     (reset_n),
        .load        (tmr_load),
        .value       (tmr_value),
        .zero        (tmr_zero)
    );

    always_ff @(posedge counter_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and timer reload; zero-length phases are skipped in the same edge.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (abort) begin
            state_nxt = IDLE;
            tmr_load  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tmr_load = 1'b1;
                        if (delay != '0) begin
                            state_nxt = DELAY;
                            tmr_value = delay - CW'(1);
                        end else if (width != '0) begin
                            state_nxt = ACTIVE;
                            tmr_value = width - CW'(1);
                        end else if (holdoff != '0) begin
                            state_nxt = HOLDOFF;
                            tmr_value = holdoff - CW'(1);
                        end
                    end
                end
                DELAY: begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        if (cfg_width != '0) begin
                            state_nxt = ACTIVE;
                            tmr_value = cfg_width - CW'(1);
                        end else if (cfg_holdoff != '0) begin
                            state_nxt = HOLDOFF;
                            tmr_value = cfg_holdoff - CW'(1);
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                ACTIVE: begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        if (cfg_holdoff != '0) begin
                            state_nxt = HOLDOFF;
                            tmr_value = cfg_holdoff - CW'(1);
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                HOLDOFF: begin
                    if (tmr_zero) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tmr_load  = 1'b1;
                end
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        sw_out_nxt = (state_nxt == ACTIVE);
        busy_nxt   = (state_nxt != IDLE);
        fire_nxt   = fire_cnt;
        missed_nxt = missed;
        if ((state_nxt == ACTIVE) && (state != ACTIVE)) begin
            fire_nxt = fire_cnt + FW'(1);
        end
        if (clr_missed) begin
            missed_nxt = 1'b0;
        end
        if (trig && (state != IDLE)) begin
            missed_nxt = 1'b1;
        end
    end

    always_ff @(posedge counter_clk or negedge reset_n) begin
        if (!reset_n) begin
            comp_q   <= 1'b0;
            sw_out   <= 1'b0;
            busy     <= 1'b0;
            fire_cnt <= '0;
            missed   <= 1'b0;
        end else begin
            comp_q   <= comp_in;
            sw_out   <= sw_out_nxt;
            busy     <= busy_nxt;
            fire_cnt <= fire_nxt;
            missed   <= missed_nxt;
        end
    end

    // Pulse shape is frozen at acceptance so input changes cannot disturb it.
    always_ff @(posedge counter_clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_width   <= '0;
            cfg_holdoff <= '0;
        end else if (accept) begin
            cfg_width   <= width;
            cfg_holdoff <= holdoff;
        end
    end

endmodule

// File: tb/tb_photonic_switch_driver.sv
// Randomized and directed bench for photonic_switch_driver against an
// event-schedule reference model.
module tb_photonic_switch_driver;

    localparam int unsigned CW = 7;
    localparam int unsigned FW = 8;

    logic          counter_clk;
    logic          reset_n;
    logic          comp_in;
    logic          arm;
    logic          abort;
    logic [CW-1:0] delay;
    logic [CW-1:0] width;
    logic [CW-1:0] holdoff;
    logic          clr_missed;
    logic          sw_out;
    logic          busy;
    logic [FW-1:0] fire_cnt;
    logic          missed;

    int total = 0;
    int bad   = 0;

    // Reference model: each accepted trigger becomes a schedule of edge numbers.
    int            e        = 0;
    int            busy_end = 0;
    int            sw_start = 0;
    int            sw_end   = 0;
    int            fire_at  = -1;
    logic          comp_prev = 1'b0;
    logic          m_missed  = 1'b0;
    logic [FW-1:0] m_fire    = '0;

    photonic_switch_driver #(.CW(CW), .FW(FW)) dut (
        .counter_clk (counter_clk),
        .reset_n     (reset_n),
        .comp_in     (comp_in),
        .arm         (arm),
        .abort       (abort),
        .delay       (delay),
        .width       (width),
        .holdoff     (holdoff),
        .clr_missed  (clr_missed),
        .sw_out      (sw_out),
        .busy        (busy),
        .fire_cnt    (fire_cnt),
        .missed      (missed)
    );

    initial begin
        counter_clk = 1'b0;
        forever #5 counter_clk = ~counter_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy_end  = e;
        sw_start  = 0;
        sw_end    = 0;
        fire_at   = -1;
        comp_prev = 1'b0;
        m_missed  = 1'b0;
        m_fire    = '0;
    endtask

    task automatic model_edge();
        bit trig;
        bit idle_before;
        e++;
        trig        = comp_in && !comp_prev;
        comp_prev   = comp_in;
        idle_before = ((e - 1) >= busy_end);
        if (trig && !idle_before) m_missed = 1'b1;
        else if (clr_missed)      m_missed = 1'b0;
        if (abort) begin
            if (busy_end > e) busy_end = e;
            if (sw_end > e)   sw_end   = e;
            if (fire_at >= e) fire_at  = -1;
        end else if (idle_before && trig && arm) begin
            sw_start = e + int'(delay);
            sw_end   = sw_start + int'(width);
            busy_end = sw_end + int'(holdoff);
            fire_at  = (width != '0) ? sw_start : -1;
        end
        if (fire_at == e) m_fire++;
    endtask

    task automatic check_all();
        check_val("sw_out",   32'(sw_out),   32'((e >= sw_start) && (e < sw_end)));
        check_val("busy",     32'(busy),     32'(e < busy_end));
        check_val("fire_cnt", 32'(fire_cnt), 32'(m_fire));
        check_val("missed",   32'(missed),   32'(m_missed));
    endtask

    task automatic step();
        @(posedge counter_clk);
        model_edge();
        @(negedge counter_clk);
        check_all();
    endtask

    task automatic drive(input logic c, input logic a, input logic ab, input logic clr,
                         input int d, input int w, input int h);
        comp_in    = c;
        arm        = a;
        abort      = ab;
        clr_missed = clr;
        delay      = CW'(d);
        width      = CW'(w);
        holdoff    = CW'(h);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_sw_out",   32'(sw_out),   32'(0));
        check_val("rst_busy",     32'(busy),     32'(0));
        check_val("rst_fire_cnt", 32'(fire_cnt), 32'(0));
        check_val("rst_missed",   32'(missed),   32'(0));
        @(negedge counter_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int cnt;
        drive(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        @(negedge counter_clk);
        do_reset();

        // Basic pulse: d=3 w=5 h=2.
        drive(1, 1, 0, 0, 3, 5, 2);
        step();
        cnt = 0;
        drive(0, 1, 0, 0, 9, 9, 9);
        for (int i = 0; i < 14; i++) begin
            step();
            if (sw_out) cnt++;
        end
        check_val("basic_width", 32'(cnt), 32'(5));
        check_val("basic_fire", 32'(fire_cnt), 32'(1));

        // Zero delay, stuck comp.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 0, 0, 1, 0);
            step();
        end
        drive(0, 1, 0, 0, 0, 1, 0);
        step();
        check_val("stuck_fire", 32'(fire_cnt), 32'(1));
        check_val("stuck_missed", 32'(missed), 32'(0));

        // Busy retrigger, clear, and clear colliding with retrigger.
        drive(1, 1, 0, 0, 0, 20, 0); step();
        drive(0, 1, 0, 0, 0, 20, 0); step();
        drive(1, 1, 0, 0, 0, 20, 0); step();
        check_val("retrig_missed", 32'(missed), 32'(1));
        drive(0, 1, 0, 1, 0, 20, 0); step();
        check_val("clr_missed", 32'(missed), 32'(0));
        drive(1, 1, 0, 1, 0, 20, 0); step();
        check_val("set_wins", 32'(missed), 32'(1));

        // Abort during ACTIVE.
        drive(0, 1, 1, 1, 0, 20, 0); step();
        check_val("abort_sw", 32'(sw_out), 32'(0));
        check_val("abort_busy", 32'(busy), 32'(0));
        drive(0, 1, 0, 0, 0, 0, 0); step();

        // width = 0: busy for delay + holdoff cycles, no pulse.
        cnt = 0;
        drive(1, 1, 0, 0, 2, 0, 3); step();
        if (busy) cnt++;
        drive(0, 1, 0, 0, 2, 0, 3);
        for (int i = 0; i < 8; i++) begin
            step();
            if (busy) cnt++;
        end
        check_val("w0_busy", 32'(cnt), 32'(5));

        // Reset between edges while the switch is driven.
        drive(1, 1, 0, 0, 0, 30, 0); step();
        drive(0, 1, 0, 0, 0, 30, 0); step();
        step();
        check_val("pre_rst_sw", 32'(sw_out), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_sw", 32'(sw_out), 32'(0));
        check_val("async_fire", 32'(fire_cnt), 32'(0));
        model_reset();
        #1;
        reset_n = 1'b1;

        // fire_cnt wrap after 256 pulses, then an unarmed trigger.
        for (int i = 0; i < 256; i++) begin
            drive(1, 1, 0, 0, 0, 1, 0); step();
            drive(0, 1, 0, 0, 0, 1, 0); step();
        end
        check_val("wrap", 32'(fire_cnt), 32'(0));
        drive(1, 0, 0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 1, 0); step();
        check_val("unarmed_missed", 32'(missed), 32'(0));
        check_val("unarmed_busy", 32'(busy), 32'(0));

        // Randomized traffic; configuration churns every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic c;
            int   d, w, h;
            c = ($urandom_range(0, 9) < 3) ? ~comp_in : comp_in;
            d = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4));
            w = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 5));
            h = int'($urandom_range(0, 3));
            drive(c, $urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) == 0, d, w, h);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
